// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32I fetch front end.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;
  typedef enum logic {FS_RESET, FS_RUN} fetch_state_e;
endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: small FIFO of fetched {pc, instr} entries; flush beats push and pop.
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  localparam int AW = $clog2(BUF_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         empty,
  output logic         full
);
  fetch_entry_t mem [BUF_DEPTH];
  logic [AW-1:0] rd, wr;
  logic do_push, do_pop;
  always_comb begin
    empty = count == '0;
    full = count == (AW+1)'(BUF_DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    head = mem[rd];
  end
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr] <= wdata;
  end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, issues fetches to a 1-cycle synchronous imem,
// buffers returned words and presents {instr, pc, pc+4} to decode.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);
  localparam int AW = $clog2(BUF_DEPTH);
  fetch_state_e state, state_next;
  logic [31:0] fetch_pc, inflight_pc;
  logic inflight, pop, push;
  fetch_entry_t head, wdata;
  logic [AW:0] count;
  logic empty, full;
  fetch_buffer #(.BUF_DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .flush(redirect_valid),
    .wdata(wdata),
    .head(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
  always_ff @(posedge clk) state <= state_next;
  // Issue only when the returning word is guaranteed a free slot after this edge's pop.
  always_comb begin
    state_next = rst ? FS_RESET : FS_RUN;
    id_valid = !rst && !empty;
    pop = id_valid && !stall;
    push = inflight && !redirect_valid;
    wdata = '{pc: inflight_pc, instr: imem_rdata};
    imem_req = !rst && !redirect_valid && state == FS_RUN &&
               (count + (AW+1)'(inflight) - (AW+1)'(pop)) < (AW+1)'(BUF_DEPTH);
    imem_addr = fetch_pc;
    id_instr = id_valid ? head.instr : NOP_INSTR;
    id_pc = id_valid ? head.pc : '0;
    id_pc_plus4 = id_valid ? head.pc + 32'd4 : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[31:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + 32'd4;
        inflight_pc <= fetch_pc;
      end
    end
  end
endmodule
